// File: rtl/pe_cluster_mc_loader.sv
// Multicast loader: scan-loaded ID table per (channel, PE), tag-matched delivery with per-PE backpressure.
// Optional MC_BROADCAST_ID_EN: an all-ones tag targets every PE of the channel.
module pe_cluster_mc_loader #(
    parameter int NUM_PE_X  = 3,
    parameter int NUM_PE_Y  = 3,
    parameter int DATA_SIZE = 8,
    parameter int ID_SIZE   = 8,
    parameter int NUM_CH    = 2,
    parameter int CNT_W     = 16,
    localparam int NUM_PE   = NUM_PE_X * NUM_PE_Y,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int NUM_ID   = NUM_CH * NUM_PE
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    enable_i,
    input  logic [ID_SIZE-1:0]      id_scan_i,
    input  logic                    id_scan_en_i,
    input  logic                    id_wren_i,
    input  logic [NUM_CH*CNT_W-1:0] cfg_count_i,
    input  logic                    start_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_SIZE-1:0]    in_data_i,
    input  logic [ID_SIZE-1:0]      in_tag_i,
    input  logic [CH_W-1:0]         in_ch_i,
    output logic [NUM_PE-1:0]       pe_valid_o,
    input  logic [NUM_PE-1:0]       pe_ready_i,
    output logic [DATA_SIZE-1:0]    pe_data_o,
    output logic [CH_W-1:0]         pe_ch_o,
    output logic                    flag_done_o,
    output logic                    nomatch_o,
    output logic                    ovf_o
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

    state_e                           state_q, state_d;
    logic [NUM_ID-1:0][ID_SIZE-1:0]   shadow_q, shadow_d;
    logic [NUM_ID-1:0][ID_SIZE-1:0]   table_q, table_d;
    logic [NUM_CH-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_PE-1:0]                pend_q, pend_d;
    logic [DATA_SIZE-1:0]             data_q, data_d;
    logic [CH_W-1:0]                  ch_q, ch_d;
    logic                             nomatch_q, nomatch_d;
    logic                             ovf_q, ovf_d;

    logic [NUM_CH-1:0] ch_done;
    logic              all_done;
    logic              sel_done;
    logic [NUM_PE-1:0] mask;
    logic              accept;
    logic              load_start;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            ch_done[c] = cnt_q[c] >= cfg_count_i[c*CNT_W +: CNT_W];
    end
    assign all_done = &ch_done;

    // Out-of-range channels keep sel_done=1 and are dropped as overflow.
    always_comb begin
        sel_done = 1'b1;
        mask     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_ch_i == CH_W'(c)) begin
                sel_done = ch_done[c];
                for (int p = 0; p < NUM_PE; p++)
                    mask[p] = (table_q[c*NUM_PE + p] == in_tag_i);
            end
        end
`ifdef MC_BROADCAST_ID_EN
        if (in_tag_i == {ID_SIZE{1'b1}})
            mask = '1;
`endif
    end

    // FSM: state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (enable_i) begin
            case (state_q)
                IDLE:    if (start_i) state_d = LOAD;
                LOAD:    if (all_done && pend_q == '0) state_d = DONE;
                DONE:    if (start_i) state_d = LOAD;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        flag_done_o = (state_q == DONE);
        in_ready_o  = enable_i && (state_q == LOAD) && ((pend_q & ~pe_ready_i) == '0);
        pe_valid_o  = enable_i ? pend_q : '0;
    end

    assign accept     = in_valid_i && in_ready_o;
    assign load_start = (state_d == LOAD) && (state_q != LOAD);

    always_comb begin
        shadow_d  = shadow_q;
        table_d   = table_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        data_d    = data_q;
        ch_d      = ch_q;
        nomatch_d = nomatch_q;
        ovf_d     = ovf_q;
        if (enable_i) begin
            if (id_scan_en_i)
                shadow_d = {id_scan_i, shadow_q[NUM_ID-1:1]};
            // Copy takes the pre-shift shadow contents.
            if (id_wren_i && state_q != LOAD)
                table_d = shadow_q;
            pend_d = pend_q & ~pe_ready_i;
            if (load_start)
                cnt_d = '0;
            if (accept) begin
                if (sel_done) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = mask;
                    data_d = in_data_i;
                    ch_d   = in_ch_i;
                    if (mask == '0) nomatch_d = 1'b1;
                    for (int c = 0; c < NUM_CH; c++)
                        if (in_ch_i == CH_W'(c) && cnt_q[c] != {CNT_W{1'b1}})
                            cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow_q  <= '0;
            table_q   <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            data_q    <= '0;
            ch_q      <= '0;
            nomatch_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            table_q   <= table_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            data_q    <= data_d;
            ch_q      <= ch_d;
            nomatch_q <= nomatch_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pe_data_o = data_q;
    assign pe_ch_o   = ch_q;
    assign nomatch_o = nomatch_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_pe_cluster_mc_loader.sv
// Directed bench for pe_cluster_mc_loader (3x3 PEs, 2 channels).
module tb_pe_cluster_mc_loader;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        enable_i = 1'b1;
    logic [7:0]  id_scan_i = '0;
    logic        id_scan_en_i = 1'b0;
    logic        id_wren_i = 1'b0;
    logic [31:0] cfg_count_i = '0;
    logic        start_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  in_data_i = '0;
    logic [7:0]  in_tag_i = '0;
    logic        in_ch_i = 1'b0;
    logic [8:0]  pe_valid_o;
    logic [8:0]  pe_ready_i = '1;
    logic [7:0]  pe_data_o;
    logic        pe_ch_o;
    logic        flag_done_o;
    logic        nomatch_o;
    logic        ovf_o;

    int tests = 0;
    int fails = 0;

    pe_cluster_mc_loader dut (
        .clk(clk), .nrst(nrst), .enable_i(enable_i),
        .id_scan_i(id_scan_i), .id_scan_en_i(id_scan_en_i), .id_wren_i(id_wren_i),
        .cfg_count_i(cfg_count_i), .start_i(start_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_tag_i(in_tag_i), .in_ch_i(in_ch_i),
        .pe_valid_o(pe_valid_o), .pe_ready_i(pe_ready_i), .pe_data_o(pe_data_o),
        .pe_ch_o(pe_ch_o), .flag_done_o(flag_done_o), .nomatch_o(nomatch_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0; enable_i = 1'b1; id_scan_i = '0; id_scan_en_i = 1'b0; id_wren_i = 1'b0;
        start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_tag_i = '0; in_ch_i = 1'b0;
        pe_ready_i = '1;
        #1; step(); step();
        nrst = 1'b1;
    endtask

    // ch0 IDs 0..8, ch1 IDs 0,0,0,1,1,1,2,2,2
    task automatic scan_table();
        for (int i = 0; i < 18; i++) begin
            id_scan_i    = (i < 9) ? 8'(i) : 8'((i - 9) / 3);
            id_scan_en_i = 1'b1;
            step();
        end
        id_scan_en_i = 1'b0;
        id_wren_i    = 1'b1;
        step();
        id_wren_i    = 1'b0;
    endtask

    task automatic start_load(input logic [15:0] c0, input logic [15:0] c1);
        cfg_count_i = {c1, c0};
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic send_word(input logic ch, input logic [7:0] tag, input logic [7:0] data);
        int n = 0;
        in_valid_i = 1'b1; in_ch_i = ch; in_tag_i = tag; in_data_i = data;
        #1;
        while (!in_ready_o && n < 20) begin step(); n++; end
        if (!in_ready_o) begin
            tests++; fails++;
            $display("FAIL send_timeout ch=%0d tag=%h in_ready got 0 want 1", ch, tag);
        end else begin
            step();
        end
        in_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!flag_done_o && n < 6) begin step(); n++; end
        tests++;
        if (flag_done_o !== 1'b1) begin fails++; $display("FAIL done_flag got %b want 1", flag_done_o); end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        #2;
        tests++;
        if ({pe_valid_o, pe_data_o, pe_ch_o, flag_done_o, nomatch_o, ovf_o, in_ready_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got v=%h d=%h ch=%b done=%b nm=%b ovf=%b rdy=%b want all 0",
                     pe_valid_o, pe_data_o, pe_ch_o, flag_done_o, nomatch_o, ovf_o, in_ready_o);
        end
        do_reset();
        step();
        tests++;
        if (in_ready_o !== 1'b0) begin fails++; $display("FAIL idle_ready got %b want 0", in_ready_o); end
    endtask

    task automatic test_multicast();
        do_reset(); scan_table(); start_load(16'd10, 16'd10);
        send_word(1'b1, 8'd1, 8'h5A);
        tests++;
        if (pe_valid_o !== 9'b000111000) begin fails++; $display("FAIL mc_valid got %b want 000111000", pe_valid_o); end
        tests++;
        if (pe_data_o !== 8'h5A || pe_ch_o !== 1'b1) begin
            fails++; $display("FAIL mc_data got %h/%b want 5a/1", pe_data_o, pe_ch_o);
        end
        step();
        tests++;
        if (pe_valid_o !== 9'b0) begin fails++; $display("FAIL mc_clear got %b want 0", pe_valid_o); end
    endtask

    task automatic test_backpressure();
        pe_ready_i = 9'b111110111;
        send_word(1'b1, 8'd1, 8'hA5);
        tests++;
        if (pe_valid_o !== 9'b000111000 || in_ready_o !== 1'b0) begin
            fails++; $display("FAIL bp_first got v=%b rdy=%b want 000111000/0", pe_valid_o, in_ready_o);
        end
        step();
        tests++;
        if (pe_valid_o !== 9'b000001000 || in_ready_o !== 1'b0) begin
            fails++; $display("FAIL bp_partial got v=%b rdy=%b want 000001000/0", pe_valid_o, in_ready_o);
        end
        step(); step();
        tests++;
        if (pe_valid_o !== 9'b000001000) begin fails++; $display("FAIL bp_hold got %b want 000001000", pe_valid_o); end
        pe_ready_i = '1;
        #1;
        tests++;
        if (in_ready_o !== 1'b1) begin fails++; $display("FAIL bp_ready got %b want 1", in_ready_o); end
        step();
        tests++;
        if (pe_valid_o !== 9'b0) begin fails++; $display("FAIL bp_release got %b want 0", pe_valid_o); end
    endtask

    task automatic test_back_to_back();
        do_reset(); scan_table(); start_load(16'd10, 16'd10);
        in_valid_i = 1'b1; in_ch_i = 1'b0; in_tag_i = 8'd0; in_data_i = 8'h11;
        step();
        tests++;
        if (pe_valid_o !== 9'h001 || pe_data_o !== 8'h11) begin
            fails++; $display("FAIL b2b_0 got v=%h d=%h want 001/11", pe_valid_o, pe_data_o);
        end
        in_tag_i = 8'd1; in_data_i = 8'h22;
        #1;
        tests++;
        if (in_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", in_ready_o); end
        step();
        tests++;
        if (pe_valid_o !== 9'h002 || pe_data_o !== 8'h22) begin
            fails++; $display("FAIL b2b_1 got v=%h d=%h want 002/22", pe_valid_o, pe_data_o);
        end
        in_ch_i = 1'b1; in_tag_i = 8'd2; in_data_i = 8'h33;
        step();
        in_valid_i = 1'b0;
        tests++;
        if (pe_valid_o !== 9'h1C0 || pe_data_o !== 8'h33 || pe_ch_o !== 1'b1) begin
            fails++; $display("FAIL b2b_2 got v=%h d=%h ch=%b want 1c0/33/1", pe_valid_o, pe_data_o, pe_ch_o);
        end
    endtask

    task automatic test_done_ovf();
        do_reset(); scan_table(); start_load(16'd3, 16'd2);
        send_word(1'b0, 8'd0, 8'h01);
        send_word(1'b0, 8'd4, 8'h02);
        send_word(1'b0, 8'd8, 8'h03);
        send_word(1'b0, 8'd1, 8'h04);
        tests++;
        if (ovf_o !== 1'b1 || pe_valid_o !== 9'b0) begin
            fails++; $display("FAIL ovf_drop got ovf=%b v=%b want 1/0", ovf_o, pe_valid_o);
        end
        tests++;
        if (flag_done_o !== 1'b0) begin fails++; $display("FAIL done_early got %b want 0", flag_done_o); end
        send_word(1'b1, 8'd2, 8'h05);
        send_word(1'b1, 8'd2, 8'h06);
        wait_done();
        tests++;
        if (in_ready_o !== 1'b0 || nomatch_o !== 1'b0) begin
            fails++; $display("FAIL done_state got rdy=%b nm=%b want 0/0", in_ready_o, nomatch_o);
        end
        start_load(16'd3, 16'd2);
        tests++;
        if (flag_done_o !== 1'b0 || in_ready_o !== 1'b1 || ovf_o !== 1'b1) begin
            fails++; $display("FAIL restart got done=%b rdy=%b ovf=%b want 0/1/1", flag_done_o, in_ready_o, ovf_o);
        end
    endtask

    task automatic test_nomatch();
        do_reset(); scan_table(); start_load(16'd2, 16'd0);
        send_word(1'b0, 8'h77, 8'h9C);
        tests++;
        if (pe_valid_o !== 9'b0 || nomatch_o !== 1'b1) begin
            fails++; $display("FAIL nomatch got v=%b nm=%b want 0/1", pe_valid_o, nomatch_o);
        end
        send_word(1'b0, 8'd5, 8'h9D);
        tests++;
        if (pe_valid_o !== 9'h020) begin fails++; $display("FAIL nomatch_next got %h want 020", pe_valid_o); end
        wait_done();
        tests++;
        if (ovf_o !== 1'b0) begin fails++; $display("FAIL nomatch_ovf got %b want 0", ovf_o); end
    endtask

    task automatic test_enable_reset();
        do_reset(); scan_table(); start_load(16'd10, 16'd10);
        pe_ready_i = '0;
        send_word(1'b0, 8'd2, 8'hC3);
        tests++;
        if (pe_valid_o !== 9'h004) begin fails++; $display("FAIL en_pend got %h want 004", pe_valid_o); end
        enable_i = 1'b0;
        #1;
        tests++;
        if (pe_valid_o !== 9'b0 || in_ready_o !== 1'b0) begin
            fails++; $display("FAIL en_low got v=%h rdy=%b want 000/0", pe_valid_o, in_ready_o);
        end
        pe_ready_i = '1;
        step();
        pe_ready_i = '0;
        enable_i = 1'b1;
        #1;
        tests++;
        if (pe_valid_o !== 9'h004) begin fails++; $display("FAIL en_restore got %h want 004", pe_valid_o); end
        nrst = 1'b0;
        #1;
        tests++;
        if (pe_valid_o !== 9'b0 || pe_data_o !== 8'h00 || flag_done_o !== 1'b0 || in_ready_o !== 1'b0) begin
            fails++; $display("FAIL midreset got v=%h d=%h done=%b rdy=%b want 0", pe_valid_o, pe_data_o, flag_done_o, in_ready_o);
        end
        pe_ready_i = '1;
        step();
        nrst = 1'b1;
        start_load(16'd10, 16'd10);
        send_word(1'b0, 8'd0, 8'h3C);
        tests++;
        if (pe_valid_o !== 9'h1FF || pe_data_o !== 8'h3C || nomatch_o !== 1'b0) begin
            fails++; $display("FAIL zero_table got v=%h d=%h nm=%b want 1ff/3c/0", pe_valid_o, pe_data_o, nomatch_o);
        end
    endtask

    task automatic test_broadcast();
        do_reset(); scan_table(); start_load(16'd10, 16'd10);
        send_word(1'b0, 8'hFF, 8'h7E);
`ifdef MC_BROADCAST_ID_EN
        tests++;
        if (pe_valid_o !== 9'h1FF || nomatch_o !== 1'b0) begin
            fails++; $display("FAIL bcast got v=%h nm=%b want 1ff/0", pe_valid_o, nomatch_o);
        end
`else
        tests++;
        if (pe_valid_o !== 9'h000 || nomatch_o !== 1'b1) begin
            fails++; $display("FAIL bcast got v=%h nm=%b want 000/1", pe_valid_o, nomatch_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_multicast();
        test_backpressure();
        test_back_to_back();
        test_done_ovf();
        test_nomatch();
        test_enable_reset();
        test_broadcast();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pe_cluster_mc_loader.md
Name: pe_cluster_mc_loader

Overview:
Multicast data loader for a NUM_PE_X x NUM_PE_Y PE cluster, for NUM_CH data channels (ch0 = weights, ch1 = activations by default).
- Holds a scan-loaded table of one multicast ID per (channel, PE).
- Accepts tagged words over a valid/ready input and delivers each word to every PE whose table ID equals the tag, with per-PE backpressure.
- Counts words per channel against configured totals and raises flag_done_o when loading completes.

Parameters:
NUM_PE_X, 3, PE columns
NUM_PE_Y, 3, PE rows; NUM_PE = NUM_PE_X*NUM_PE_Y, PE index = y*NUM_PE_X + x
DATA_SIZE, 8, data word width
ID_SIZE, 8, multicast ID/tag width
NUM_CH, 2, channel count; CH_W = max(1, clog2(NUM_CH))
CNT_W, 16, per-channel word counter width

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
enable_i  in  1  block enable
id_scan_i  in  ID_SIZE  scan-in ID
id_scan_en_i  in  1  shift id_scan_i into shadow chain this cycle
id_wren_i  in  1  copy shadow chain to active ID table
cfg_count_i  in  NUM_CH*CNT_W  words expected per channel (ch0 in LSBs)
start_i  in  1  begin load phase
in_valid_i  in  1  input word valid
in_ready_o  out  1  input word accepted when valid & ready
in_data_i  in  DATA_SIZE  input word
in_tag_i  in  ID_SIZE  multicast tag
in_ch_i  in  CH_W  channel of word
pe_valid_o  out  NUM_PE  per-PE delivery valid
pe_ready_i  in  NUM_PE  per-PE ready
pe_data_o  out  DATA_SIZE  delivered word (shared)
pe_ch_o  out  CH_W  delivered channel
flag_done_o  out  1  load complete
nomatch_o  out  1  sticky: accepted word matched no PE
ovf_o  out  1  sticky: word for an already-complete channel

Behaviour:
- Reset (async, nrst low): ID table, shadow chain, counters, pe_valid_o, pe_data_o, pe_ch_o, flag_done_o, nomatch_o, ovf_o all 0; state IDLE. Applies mid-transfer; pending deliveries are lost.
- ID scan:
  - Shadow chain has NUM_CH*NUM_PE entries of ID_SIZE, entry = ch*NUM_PE + pe.
  - With enable_i & id_scan_en_i, chain shifts toward entry 0 and id_scan_i enters the last entry. After NUM_CH*NUM_PE shifts, the first ID shifted in sits in entry 0.
  - Shifting is allowed in any state.
  - id_wren_i copies the whole shadow chain to the active table in one cycle, only in IDLE or DONE; it is ignored in LOAD.
  - id_scan_en_i and id_wren_i in the same cycle: the copy takes pre-shift shadow contents.
- FSM IDLE/LOAD/DONE:
  - IDLE->LOAD on start_i & enable_i; channel counters cleared.
  - LOAD->DONE when every channel counter >= its cfg_count and pe_valid_o == 0.
  - DONE->LOAD on start_i (counters cleared, stickies kept).
  - start_i in LOAD is ignored.
  - cfg_count 0 means that channel is complete at start.
  - cfg_count_i is sampled continuously and must be held stable during LOAD.
- Acceptance:
  - in_ready_o = enable_i & state==LOAD & (pending == 0 | (pending & ~pe_ready_i) == 0), where pending = pe_valid_o.
  - in_ready_o is 0 in IDLE and DONE.
- On accept:
  - If in_ch_i's channel is already complete: drop the word, set ovf_o, no count.
  - Otherwise: increment that channel's counter (saturating at 2^CNT_W-1), compute mask[p] = (table[ch][p] == in_tag_i), and register data, channel and mask next cycle (latency 1).
  - Mask all-zero: set nomatch_o, nothing delivered, count still increments.
  - in_ch_i >= NUM_CH: treated as already complete (ovf_o).
- Delivery:
  - Each pe_valid_o[p] clears individually on the cycle pe_ready_i[p] is sampled high.
  - pe_data_o/pe_ch_o hold until all bits clear or a new word loads.
  - Back-to-back accepts give full throughput when all targeted PEs are ready.
- enable_i low: no shift, copy, accept or state change; pe_valid_o is driven 0 and PE handshakes do not complete; internal pending mask is retained and reappears when enable_i returns.
- flag_done_o = 1 exactly while in DONE.

Optional Feature:
MC_BROADCAST_ID_EN:
- Defined: in_tag_i all-ones matches every PE for that channel regardless of table contents, and never sets nomatch_o.
- Undefined: all-ones is an ordinary tag compared against the table.

Test Plan:
- Scan 18 IDs (ch0: 0..8; ch1: 0,0,0,1,1,1,2,2,2), pulse id_wren_i, start, send ch1 tag 1 data 0x5A with all ready -> next cycle pe_valid_o=9'b000111000, pe_data_o=0x5A, pe_ch_o=1; clears after one cycle.
- Same word with pe_ready_i[3]=0 for 3 cycles -> bits 4,5 clear after first cycle, bit 3 held; in_ready_o=0 until PE3 ready, then 1.
- cfg ch0=3, ch1=2; send 3 ch0 + 2 ch1 words, all ready -> flag_done_o=1 one cycle after last delivery; in_ready_o=0 in DONE. Extra ch0 word sent before the ch1 words -> accepted, dropped, ovf_o=1.
- Tag 0x77 on ch0 -> accepted, pe_valid_o stays 0, nomatch_o=1, ch0 counter +1.
- Assert nrst low while pe_valid_o!=0 in LOAD -> all outputs 0 immediately; table reads 0, so tag 0 then matches all 9 PEs after restart.
- With MC_BROADCAST_ID_EN, tag 0xFF on ch0 -> pe_valid_o=9'h1FF; without it -> nomatch_o=1.
